// File: rtl/cache_miss_ctrl_pkg.sv
// Shared types and default geometry for the data-cache miss/write-through sequencer.
// Geometry-dependent widths inside the controller are derived from its own parameters.
package cache_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_SETS       = 8;
  localparam int DEF_LINE_WORDS = 4;

  localparam int OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int TAG_W = DEF_ADDR_W - 2 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_split_t;

  function automatic addr_split_t split_addr(input logic [DEF_ADDR_W-1:0] addr);
    addr_split_t s;
    s.off = addr[2 +: OFF_W];
    s.idx = addr[2 + OFF_W +: IDX_W];
    s.tag = addr[DEF_ADDR_W-1 -: TAG_W];
    return s;
  endfunction

endpackage

// File: rtl/cache_miss_ctrl_lru_table.sv
// Per-set LRU bit storage for the 2-way cache; each bit names the victim way of its set.
module lru_table
  import cache_pkg::*;
#(
  parameter int SETS  = DEF_SETS,
  parameter int IDX_BITS = $clog2(SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_bit,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_bit
);

  logic [SETS-1:0] bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
    end else if (wr_en) begin
      bits[wr_idx] <= wr_bit;
    end
  end

  assign rd_bit = bits[rd_idx];

endmodule

// File: rtl/cache_miss_ctrl.sv
// Miss / write-through sequencer for the 2-way set-associative D-cache in the M stage:
// stalls the pipeline, refills the LRU victim on load miss, holds stores until memory acks.
module cache_miss_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int OFF_BITS  = $clog2(LINE_WORDS),
  localparam int IDX_BITS  = $clog2(SETS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_m,
  input  logic                store_m,
  input  logic [ADDR_W-1:0]   addr_m,
  input  logic [1:0]          hit_way,
  output logic                stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_ready,
  output logic                refill_we,
  output logic                refill_way,
  output logic [OFF_BITS-1:0] refill_off,
  output logic                line_valid
);

  localparam int BASE_W = ADDR_W - 2 - OFF_BITS;
  localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

  state_t state, state_nxt;

  logic [OFF_BITS-1:0] cnt;
  logic [IDX_BITS-1:0] idx, idx_q;
  logic [BASE_W-1:0]   base_q;
  logic [ADDR_W-3:0]   word_q;
  logic                victim_q;
  logic                from_refill_q;

  logic any_hit, miss;
  logic lru_rd, lru_we, lru_wbit;
  logic [IDX_BITS-1:0] lru_widx;
  logic unused_byte_off;

  assign idx             = addr_m[2 + OFF_BITS +: IDX_BITS];
  assign any_hit         = |hit_way;
  assign miss            = load_m & ~any_hit;
  assign unused_byte_off = ^addr_m[1:0];

  lru_table #(
    .SETS     (SETS),
    .IDX_BITS (IDX_BITS)
  ) u_lru (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_idx (idx),
    .rd_bit (lru_rd),
    .wr_en  (lru_we),
    .wr_idx (lru_widx),
    .wr_bit (lru_wbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Miss/store context is captured on the IDLE cycle so later states never depend on addr_m.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      idx_q         <= '0;
      base_q        <= '0;
      word_q        <= '0;
      victim_q      <= 1'b0;
      from_refill_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss) begin
            cnt           <= '0;
            idx_q         <= idx;
            base_q        <= addr_m[ADDR_W-1 -: BASE_W];
            victim_q      <= lru_rd;
            from_refill_q <= 1'b1;
          end else if (store_m) begin
            word_q        <= addr_m[ADDR_W-1:2];
            from_refill_q <= 1'b0;
          end
        end
        REFILL: begin
          if (mem_ready && cnt != LAST_BEAT) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (miss) begin
          state_nxt = REFILL;
        end else if (store_m) begin
          state_nxt = WRITE;
        end
      end
      REFILL:  if (mem_ready && cnt == LAST_BEAT) state_nxt = DONE;
      WRITE:   if (mem_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of M-stage inputs.
  always_comb begin
    stall      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    refill_we  = 1'b0;
    refill_way = 1'b0;
    refill_off = '0;
    line_valid = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: stall = miss | store_m;
        REFILL: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = {base_q, cnt, 2'b00};
          if (mem_ready) begin
            refill_we  = 1'b1;
            refill_way = victim_q;
            refill_off = cnt;
            line_valid = (cnt == LAST_BEAT);
          end
        end
        WRITE: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = {word_q, 2'b00};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lru_we   = 1'b0;
    lru_widx = idx;
    lru_wbit = 1'b0;
    if (state == IDLE && (load_m || store_m) && any_hit) begin
      lru_we   = 1'b1;
      lru_widx = idx;
      lru_wbit = ~hit_way[1];
    end else if (state == DONE && from_refill_q) begin
      lru_we   = 1'b1;
      lru_widx = idx_q;
      lru_wbit = ~victim_q;
    end
  end

  a_no_load_and_store: assert property (@(posedge clk) disable iff (!rst_n) !(load_m && store_m));

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: a tag/valid/LRU cache model supplies hit_way
// and predicts every bus beat, refill way and stall count.
module tb_cache_miss_ctrl;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_m = 1'b0;
  logic        store_m = 1'b0;
  logic [31:0] addr_m = '0;
  logic [1:0]  hit_way = '0;
  logic        mem_ready = 1'b0;
  logic        stall, mem_req, mem_we, refill_we, refill_way, line_valid;
  logic [31:0] mem_addr;
  logic [1:0]  refill_off;

  cache_miss_ctrl #(
    .ADDR_W     (32),
    .SETS       (8),
    .LINE_WORDS (LW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_m     (load_m),
    .store_m    (store_m),
    .addr_m     (addr_m),
    .hit_way    (hit_way),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_ready  (mem_ready),
    .refill_we  (refill_we),
    .refill_way (refill_way),
    .refill_off (refill_off),
    .line_valid (line_valid)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_seen = 0;

  logic [24:0] mtag [8][2];
  bit          mval [8][2];
  bit          mlru [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_hit(input logic [31:0] a);
    logic [1:0] hw;
    int s;
    s = int'(a[6:4]);
    for (int w = 0; w < 2; w++) hw[w] = mval[s][w] && (mtag[s][w] == a[31:7]);
    return hw;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      mlru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        mval[s][w] = 1'b0;
        mtag[s][w] = '0;
      end
    end
  endtask

  function automatic int pick_wait();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
  endfunction

  task automatic note_stall();
    if (stall === 1'b1) stall_seen++;
  endtask

  task automatic do_load(input logic [31:0] a, input int w0, input bit rnd);
    int s, st0, waits, w;
    logic [1:0] hw;
    bit vic;
    s = int'(a[6:4]);
    hw = model_hit(a);
    st0 = stall_seen;
    waits = 0;
    @(negedge clk);
    load_m = 1'b1; store_m = 1'b0; addr_m = a; hit_way = hw; mem_ready = 1'b0;
    #1 note_stall();
    check("ld_idle_stall", stall, (hw == 2'b00));
    check("ld_idle_req", mem_req, 0);
    if (hw != 2'b00) begin
      mlru[s] = ~hw[1];
      check("ld_hit_stalls", stall_seen - st0, 0);
    end else begin
      vic = mlru[s];
      for (int b = 0; b < LW; b++) begin
        w = (b == 0) ? w0 : 0;
        if (rnd) w = pick_wait();
        waits += w;
        for (int k = 0; k <= w; k++) begin
          @(negedge clk);
          mem_ready = (k == w);
          #1 note_stall();
          check("rf_stall", stall, 1);
          check("rf_req", mem_req, 1);
          check("rf_we", mem_we, 0);
          check("rf_addr", mem_addr, {a[31:4], 4'b0000} + 32'(4 * b));
          check("rf_wr", refill_we, mem_ready);
          check("rf_lv", line_valid, (mem_ready && b == LW - 1));
          if (mem_ready) begin
            check("rf_way", refill_way, vic);
            check("rf_off", refill_off, 32'(b));
          end
        end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1 note_stall();
      check("ld_done_stall", stall, 0);
      check("ld_done_req", mem_req, 0);
      check("ld_done_lv", line_valid, 0);
      mtag[s][vic] = a[31:7];
      mval[s][vic] = 1'b1;
      mlru[s] = ~vic;
      check("ld_miss_stalls", stall_seen - st0, 1 + LW + waits);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input int w_in, input bit rnd);
    int s, st0, w;
    logic [1:0] hw;
    s = int'(a[6:4]);
    hw = model_hit(a);
    st0 = stall_seen;
    w = rnd ? pick_wait() : w_in;
    @(negedge clk);
    load_m = 1'b0; store_m = 1'b1; addr_m = a; hit_way = hw; mem_ready = 1'b0;
    #1 note_stall();
    check("st_idle_stall", stall, 1);
    check("st_idle_req", mem_req, 0);
    if (hw != 2'b00) mlru[s] = ~hw[1];
    for (int k = 0; k <= w; k++) begin
      @(negedge clk);
      mem_ready = (k == w);
      #1 note_stall();
      check("wr_stall", stall, 1);
      check("wr_req", mem_req, 1);
      check("wr_we", mem_we, 1);
      check("wr_addr", mem_addr, a & 32'hFFFF_FFFC);
      check("wr_rfwe", refill_we, 0);
      check("wr_lv", line_valid, 0);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    #1 note_stall();
    check("st_done_stall", stall, 0);
    check("st_done_req", mem_req, 0);
    check("st_stalls", stall_seen - st0, 2 + w);
  endtask

  task automatic do_idle();
    @(negedge clk);
    load_m = 1'b0; store_m = 1'b0; hit_way = '0; mem_ready = 1'b0;
    #1;
    check("idle_stall", stall, 0);
    check("idle_req", mem_req, 0);
  endtask

  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    int r;
    logic [31:0] a;
    model_reset();

    // Outputs held low in reset even with a missing load presented.
    #1;
    load_m = 1'b1; hit_way = 2'b00; addr_m = 32'h124;
    #1;
    check("rst_stall", stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_rfwe", refill_we, 0);
    load_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Line refill: four beats from 0x120, way 0, five stall cycles.
    do_load(32'h0000_0124, 0, 1'b0);
    do_load(32'h0000_01A4, 0, 1'b0);

    // Set 5: fill both ways, hit way 1, next miss evicts way 0.
    do_load(32'h0000_0050, 0, 1'b0);
    do_load(32'h0000_00D0, 0, 1'b0);
    do_load(32'h0000_00D4, 0, 1'b0);
    do_load(32'h0000_0150, 0, 1'b0);

    // Store with three memory wait cycles.
    do_store(32'h0000_0040, 3, 1'b0);

    // Store then load miss on the same set; first refill beat waits two cycles.
    do_store(32'h0000_0060, 0, 1'b0);
    do_load(32'h0000_0064, 2, 1'b0);

    // Reset in the middle of a refill (cnt=2) abandons it; LRU returns to way 0.
    do_load(32'h0000_0030, 0, 1'b0);
    @(negedge clk);
    load_m = 1'b1; store_m = 1'b0; addr_m = 32'h0000_00B0; hit_way = model_hit(32'h0000_00B0);
    mem_ready = 1'b0;
    #1 check("mr_idle_stall", stall, 1);
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1 check("mr_way", refill_way, 1);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1 check("mr_addr", mem_addr, 32'h0000_00B8);
    rst_n = 1'b0;
    #1;
    check("mr_rst_stall", stall, 0);
    check("mr_rst_req", mem_req, 0);
    check("mr_rst_rfwe", refill_we, 0);
    check("mr_rst_lv", line_valid, 0);
    load_m = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_load(32'h0000_00B0, 0, 1'b0);
    do_idle();

    // Randomised mix of loads, stores and bubbles against the cache model.
    for (int i = 0; i < 2000; i++) begin
      a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4)
        | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      r = int'($urandom_range(0, 99));
      if (r < 60)      do_load(a, 0, 1'b1);
      else if (r < 90) do_store(a, 0, 1'b1);
      else             do_idle();
    end
    do_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
